// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default operand width for mult_iter
package mult_pkg;
  localparam int MULT_WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mult_iter.sv
// mult_iter: iterative shift-add multiplier; define MULT_EARLY_TERM_EN to finish once the multiplier runs out of set bits
module mult_iter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mult_begin,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_end,
  output logic               overflow,
  output logic               mult_busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic begin_q, begin_d;
  logic sign_q, sign_d;
  logic signed_q, signed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic end_q, end_d;
  logic ovf_q, ovf_d;
  logic [WIDTH-1:0] mag1, mag2, mplier_sh;
  logic [2*WIDTH-1:0] res;
  logic res_ovf, early;
  assign mag1 = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
  assign mag2 = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
  assign mplier_sh = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
  assign early = mplier_sh == '0;
`else
  assign early = 1'b0;
`endif
  assign res = sign_q ? -acc_q : acc_q;
  assign res_ovf = signed_q ? !((&res[2*WIDTH-1:WIDTH-1]) || !(|res[2*WIDTH-1:WIDTH-1]))
                            : |res[2*WIDTH-1:WIDTH];
  assign product = product_q;
  assign mult_end = end_q;
  assign overflow = ovf_q;
  assign mult_busy = state_q != IDLE;

  // next-state and datapath: start on a begin rising edge, shift-add per CALC edge, publish on DONE
  always_comb begin
    state_d = state_q;
    begin_d = mult_begin;
    sign_d = sign_q;
    signed_d = signed_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    product_d = product_q;
    end_d = 1'b0;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (mult_begin && !begin_q) begin
        state_d = CALC;
        sign_d = mult_signed && (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
        signed_d = mult_signed;
        cnt_d = CW'(WIDTH);
        mcand_d = {{WIDTH{1'b0}}, mag1};
        mplier_d = mag2;
        acc_d = '0;
      end
      CALC: if (!mult_begin) state_d = IDLE;
      else begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1) || early) ? DONE : CALC;
      end
      DONE: begin
        product_d = res;
        ovf_d = res_ovf;
        end_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      begin_q <= 1'b0;
      sign_q <= 1'b0;
      signed_q <= 1'b0;
      cnt_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      product_q <= '0;
      end_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      begin_q <= begin_d;
      sign_q <= sign_d;
      signed_q <= signed_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      product_q <= product_d;
      end_q <= end_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mult_iter.sv
// tb_mult_iter: scoreboard bench for mult_iter with directed corners and random operands
module tb_mult_iter;
  localparam int W = 32;
  typedef struct {
    logic [63:0] p;
    logic        o;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic mult_begin = 1'b0;
  logic mult_signed = 1'b0;
  logic [W-1:0] mult_op1 = '0;
  logic [W-1:0] mult_op2 = '0;
  logic [2*W-1:0] product;
  logic mult_end, overflow, mult_busy;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int ends_seen = 0;
  exp_t sb[$];
  exp_t e;

  mult_iter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .mult_begin(mult_begin), .mult_signed(mult_signed),
    .mult_op1(mult_op1), .mult_op2(mult_op2), .product(product),
    .mult_end(mult_end), .overflow(overflow), .mult_busy(mult_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model_p(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = s ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
    y = s ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    return 64'(x * y);
  endfunction

  function automatic logic model_o(input bit s, input logic [63:0] p);
    if (s) return ($signed(p) > 64'sd2147483647) || ($signed(p) < -64'sd2147483648);
    return p > 64'h00000000FFFFFFFF;
  endfunction

  function automatic int model_lat(input bit s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int hi;
    m = (s && b[31]) ? 32'(0 - b) : b;
    hi = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i;
    return hi + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold,
                     input bit have_exp, input logic [63:0] ep, input logic eo);
    exp_t x;
    @(negedge clk);
    mult_begin = 1'b0;
    @(negedge clk);
    mult_signed = s;
    mult_op1 = a;
    mult_op2 = b;
    mult_begin = 1'b1;
    x.p = have_exp ? ep : model_p(s, a, b);
    x.o = have_exp ? eo : model_o(s, model_p(s, a, b));
    x.cyc = cyc + 1 + model_lat(s, b);
    sb.push_back(x);
    @(negedge clk);
    chk("busy_after_start", 64'(mult_busy), 64'd1);
    repeat (hold - 1) @(negedge clk);
    mult_begin = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // monitor: pop and compare on every completion pulse
  always @(posedge clk) begin
    #1;
    if (mult_end) begin
      ends_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end: mult_end high with no pending operation (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("product", product, e.p);
        chk("overflow", 64'(overflow), 64'(e.o));
        chk("end_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    bit s;
    repeat (3) @(negedge clk);
    chk("reset_product", product, 64'd0);
    chk("reset_end", 64'(mult_end), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_busy", 64'(mult_busy), 64'd0);
    resetn = 1'b1;
    run(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 40, 1, 64'h3FFFFFFF00000001, 1'b1);
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1, 64'h0000000000000001, 1'b0);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1, 64'hFFFFFFFE00000001, 1'b1);
    run(1, 32'h80000000, 32'h00000001, 34, 1, 64'hFFFFFFFF80000000, 1'b0);
    run(1, 32'h80000000, 32'hFFFFFFFF, 34, 1, 64'h0000000080000000, 1'b1);
    repeat (3) @(negedge clk);
    chk("ends_before_abort", 64'(ends_seen), 64'd5);
    @(negedge clk);
    mult_begin = 1'b0;
    @(negedge clk);
    mult_signed = 1'b0;
    mult_op1 = 32'd3;
    mult_op2 = 32'd4;
    mult_begin = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 64'(mult_busy), 64'd1);
    mult_begin = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(mult_busy), 64'd0);
    chk("abort_product", product, 64'h0000000080000000);
    chk("abort_ovf", 64'(overflow), 64'd1);
    repeat (40) @(negedge clk);
    chk("abort_no_end", 64'(ends_seen), 64'd5);
    run(0, 32'd5, 32'd2, 34, 1, 64'd10, 1'b0);
    run(0, 32'd7, 32'd0, 34, 1, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    mult_begin = 1'b0;
    @(negedge clk);
    mult_op1 = 32'd9;
    mult_op2 = 32'hFFFF;
    mult_begin = 1'b1;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    mult_begin = 1'b0;
    #1;
    chk("rst_product", product, 64'd0);
    chk("rst_end", 64'(mult_end), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(mult_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_end", 64'(ends_seen), 64'd7);
    chk("rst_idle", 64'(mult_busy), 64'd0);
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      run(s, a, b, 33 + $urandom_range(0, 4), 0, 64'd0, 1'b0);
    end
    repeat (60) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("total_ends", 64'(ends_seen), 64'd27);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
